// File: rtl/regfile_pkg.sv
// Shared constants and the byte-lane strobe merge used by the register file
// for both the write path and the bypass path.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // One byte lane of a strobed write: new byte when enabled, stored byte otherwise.
  function automatic logic [7:0] strb_merge_byte(
    input logic [7:0] old_byte,
    input logic [7:0] new_byte,
    input logic       en
  );
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: pending-destination vector with write/alloc/flush
// priority and a registered population count that tracks it exactly.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic                alloc,
  input  logic [ADDR_W-1:0]   alloc_addr,
  input  logic                flush,
  output logic [2**ADDR_W-1:0] busy,
  output logic [ADDR_W:0]     busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic             wr_ok;
  logic             alloc_ok;
  logic             inc;
  logic             dec;
  logic [DEPTH-1:0] busy_nxt;
  logic [ADDR_W:0]  cnt_nxt;

  assign wr_ok    = we    && !((ZERO_REG != 0) && (waddr == '0));
  assign alloc_ok = alloc && !((ZERO_REG != 0) && (alloc_addr == '0));

  // Alloc after write-clear so a same-address alloc leaves the entry busy.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)    busy_nxt[waddr]      = 1'b0;
    if (alloc_ok) busy_nxt[alloc_addr] = 1'b1;
    if (flush)    busy_nxt             = '0;
  end

  assign inc = alloc_ok && !busy[alloc_addr];
  assign dec = wr_ok && busy[waddr] && !(alloc_ok && (alloc_addr == waddr));

  always_comb begin
    cnt_nxt = busy_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
    if (flush) cnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with byte-strobed writes, optional
// write-to-read bypass and an integrated busy-bit scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic                     alloc,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NBYTE = DATA_W/8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_ok;
  logic              alloc_ok;
  logic [DATA_W-1:0] wr_new;

  assign wr_ok    = we    && !((ZERO_REG != 0) && (waddr == '0));
  assign alloc_ok = alloc && !((ZERO_REG != 0) && (alloc_addr == '0));

  always_comb begin
    wr_new = mem[waddr];
    for (int b = 0; b < NBYTE; b++)
      wr_new[b*8 +: 8] = strb_merge_byte(mem[waddr][b*8 +: 8], wdata[b*8 +: 8], wstrb[b]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wr_new;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .waddr      (waddr),
    .alloc      (alloc),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy       (busy),
    .busy_cnt   (busy_cnt)
  );

  // Bypass is suppressed while reset is held: that write will be discarded.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              zero_hit;
    logic              byp_hit;
    logic              alloc_hit;

    assign a         = raddr[i*ADDR_W +: ADDR_W];
    assign zero_hit  = (ZERO_REG != 0) && (a == '0);
    assign byp_hit   = (BYPASS != 0) && wr_ok && !reset && (waddr == a);
    assign alloc_hit = alloc_ok && (alloc_addr == a);

    assign rdata[i*DATA_W +: DATA_W] = zero_hit ? '0 : (byp_hit ? wr_new : mem[a]);
    assign rbusy[i] = zero_hit ? 1'b0 : (byp_hit ? alloc_hit : busy[a]);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios then random traffic
// against an array-based reference model.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic [3:0]       wstrb;
  logic             alloc;
  logic [AW-1:0]    alloc_addr;
  logic             flush;
  logic [AW:0]      busy_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_m [DEPTH];
  bit            busy_m [DEPTH];

  regfile_sb #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .alloc(alloc), .alloc_addr(alloc_addr), .flush(flush), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input int a);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = mem_m[a];
    if (!reset && we && (int'(waddr) == a))
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) v[b*8 +: 8] = wdata[b*8 +: 8];
    return v;
  endfunction

  function automatic bit m_busy(input int a);
    if (a == 0 || reset) return 1'b0;
    if (we && (int'(waddr) == a)) return alloc && (int'(alloc_addr) == a);
    return busy_m[a];
  endfunction

  function automatic int m_cnt();
    int n = 0;
    for (int e = 0; e < DEPTH; e++) n += int'(busy_m[e]);
    return n;
  endfunction

  task automatic model_clear();
    for (int e = 0; e < DEPTH; e++) begin
      mem_m[e]  = '0;
      busy_m[e] = 1'b0;
    end
  endtask

  task automatic model_clock();
    if (we && waddr != 0) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem_m[waddr][b*8 +: 8] = wdata[b*8 +: 8];
      busy_m[waddr] = 1'b0;
    end
    if (alloc && alloc_addr != 0) busy_m[alloc_addr] = 1'b1;
    if (flush)
      for (int e = 0; e < DEPTH; e++) busy_m[e] = 1'b0;
  endtask

  task automatic check_reads(input string tag);
    for (int i = 0; i < NR; i++) begin
      int a;
      a = int'(raddr[i*AW +: AW]);
      chk({tag, "_rd"}, 64'(rdata[i*DW +: DW]), 64'(m_read(a)));
      chk({tag, "_rb"}, 64'(rbusy[i]), 64'(m_busy(a)));
    end
  endtask

  // Inputs are set just after a posedge; reads checked mid-cycle, count after the edge.
  task automatic step(input string tag);
    #2;
    check_reads(tag);
    @(posedge clk);
    model_clock();
    #1;
    chk({tag, "_cnt"}, 64'(busy_cnt), 64'(m_cnt()));
  endtask

  task automatic drive(input logic w, input int wa, input logic [DW-1:0] wd,
                       input logic [3:0] ws, input logic al, input int aa, input logic fl);
    we = w; waddr = AW'(wa); wdata = wd; wstrb = ws;
    alloc = al; alloc_addr = AW'(aa); flush = fl;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    raddr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic idle();
    drive(1'b0, 0, '0, 4'h0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    set_rd(0, 1, 2, 3);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reads("rst_init");
    chk("rst_init_cnt", 64'(busy_cnt), 64'd0);
    reset = 1'b0;

    drive(1'b1, 5, 32'hCAFEF00D, 4'hF, 1'b1, 6, 1'b0); set_rd(5, 6, 5, 6); step("pre0");
    drive(1'b0, 0, '0, 4'h0, 1'b1, 8, 1'b0); step("pre1");

    // Reset lands mid-cycle while a write and alloc are in flight.
    drive(1'b1, 5, 32'h0BADC0DE, 4'hF, 1'b1, 10, 1'b0); set_rd(5, 6, 8, 10);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_reads("rst_mid");
    chk("rst_mid_cnt", 64'(busy_cnt), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_cnt", 64'(busy_cnt), 64'd0);
    reset = 1'b0;

    drive(1'b1, 5, 32'hDEADBEEF, 4'hF, 1'b0, 0, 1'b0); set_rd(5, 5, 5, 5); step("w5");
    idle(); #1; chk("r5_const", 64'(rdata[DW-1:0]), 64'hDEADBEEF); step("r5");

    drive(1'b1, 3, 32'h11223344, 4'hF, 1'b0, 0, 1'b0); set_rd(3, 3, 3, 3); step("w3");
    drive(1'b1, 3, 32'hAABBCCDD, 4'b0101, 1'b0, 0, 1'b0);
    #1; chk("strb_byp", 64'(rdata[DW-1:0]), 64'h11BB33DD); step("strb");
    idle(); #1; chk("strb_held", 64'(rdata[DW-1:0]), 64'h11BB33DD); step("r3");

    drive(1'b1, 0, 32'hFFFFFFFF, 4'hF, 1'b1, 0, 1'b0); set_rd(0, 0, 0, 0);
    #1; chk("zero_rd", 64'(rdata[DW-1:0]), 64'd0); chk("zero_rb", 64'(rbusy), 64'd0);
    step("zero_w");
    chk("zero_cnt", 64'(busy_cnt), 64'd0);
    idle(); step("zero_r");

    set_rd(7, 9, 7, 9);
    drive(1'b0, 0, '0, 4'h0, 1'b1, 7, 1'b0); step("sb_a7");
    drive(1'b0, 0, '0, 4'h0, 1'b1, 9, 1'b0); step("sb_a9");
    chk("sb_two", 64'(busy_cnt), 64'd2);
    drive(1'b1, 7, 32'h00000077, 4'hF, 1'b0, 0, 1'b0); step("sb_w7");
    chk("sb_one", 64'(busy_cnt), 64'd1);
    drive(1'b1, 9, 32'h99999999, 4'h0, 1'b1, 9, 1'b0);
    #1; chk("sb_r9_byp_busy", 64'(rbusy[1]), 64'd1); step("sb_aw9");
    chk("sb_still_one", 64'(busy_cnt), 64'd1);
    idle(); #1; chk("sb_r9_busy", 64'(rbusy[1]), 64'd1); step("sb_r9");

    drive(1'b0, 0, '0, 4'h0, 1'b1, 1, 1'b0); step("fl_a1");
    drive(1'b0, 0, '0, 4'h0, 1'b1, 2, 1'b0); step("fl_a2");
    chk("fl_three", 64'(busy_cnt), 64'd3);
    drive(1'b1, 4, 32'h00000005, 4'hF, 1'b1, 4, 1'b1); set_rd(4, 1, 2, 9); step("fl_go");
    chk("fl_cnt", 64'(busy_cnt), 64'd0);
    idle();
    #1; chk("fl_r4", 64'(rdata[DW-1:0]), 64'd5); chk("fl_r4_busy", 64'(rbusy[0]), 64'd0);
    step("fl_r");

    set_rd(12, 12, 12, 12);
    drive(1'b1, 12, 32'h12345678, 4'hF, 1'b0, 0, 1'b0);
    #1;
    for (int i = 0; i < NR; i++)
      chk("stress_rd", 64'(rdata[i*DW +: DW]), 64'h12345678);
    chk("stress_rb", 64'(rbusy), 64'd0);
    step("stress");

    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom), int'($urandom_range(0, 7)), $urandom, 4'($urandom),
            1'($urandom), int'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
      set_rd(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with byte-strobed writes, optional write-to-read bypass and an integrated busy-bit scoreboard for pending destination registers. It sits in the CPU decode/writeback boundary. Decode reads operands and checks busy status. Issue allocates destinations. Writeback commits results and releases them.

## Interface
Parameters:
- DATA_W, 32, register width in bits; multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 entry 0 reads 0, is never written and is never busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- raddr  in  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  read data per port.
- rbusy  out  NUM_RD  per-port busy flag of the addressed entry.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte enables; only enabled bytes update.
- alloc  in  1  mark alloc_addr as pending (busy).
- alloc_addr  in  ADDR_W  destination being allocated.
- flush  in  1  clear all busy bits; data is untouched.
- busy_cnt  out  ADDR_W+1  number of entries currently busy.

## Operation
- Reset: every data entry is 0, every busy bit is 0, and busy_cnt is 0. Asserting reset mid-operation discards any in-flight write or alloc.
- Write: on posedge with we=1, for each byte b where wstrb[b]=1, entry[waddr] byte b takes wdata byte b. A write clears busy[waddr].
- Write with wstrb=0: the data is unchanged, but busy[waddr] still clears. This is a release-only writeback.
- Alloc: on posedge with alloc=1, busy[alloc_addr] is set.
- Write and alloc to the same address in one cycle: the data is written and busy ends at 1, because the new producer wins.
- Flush: busy bits clear to 0 and busy_cnt goes to 0. Flush has priority over alloc in the same cycle. A write in a flush cycle still commits its data.
- ZERO_REG=1: writes and allocs to address 0 are ignored. Reads of address 0 return 0 with rbusy=0.
- Read, combinational: rdata[i] = entry[raddr[i]].
  - With BYPASS=1 and we=1 and waddr==raddr[i] (and the address is not 0 when ZERO_REG=1), rdata[i] is the strobe-merged value: enabled bytes come from wdata, the rest from the stored entry.
  - In the same bypass case, rbusy[i] = 0 unless alloc targets the same address in that cycle.
- BYPASS=0: reads return pre-write contents and rbusy reflects pre-edge state.
- busy_cnt: registered. It is updated every cycle by the net change: +1 per newly set bit, -1 per newly cleared bit. It must always equal the popcount of the busy vector; it never wraps.

## Timing
- Read latency 0: rdata and rbusy are combinational from raddr and state, and from write inputs when BYPASS=1.
- Write and alloc take effect at the next posedge and are visible to non-bypassed reads from the following cycle.
- busy_cnt reflects the busy vector as of the last posedge, with no extra lag.
- All read ports are independent; identical addresses on several ports return identical values.

## Structure
- Shared package regfile_pkg holds the default DATA_W/ADDR_W constants and a function for the strobe-merge of stored data with wdata.
- Sub-module regfile_scoreboard contains the busy vector, the alloc/write/flush priority logic and the busy_cnt counter.
- The top level contains the data array, the read muxes and the bypass logic.

## Test plan
- Reset check: assert reset mid-stream with we=1 -> all reads return 0x00000000, rbusy=0 and busy_cnt=0 immediately. After release, a write of 0xDEADBEEF to r5 reads back from the next cycle.
- Strobe merge: write r3=0x11223344, then we with wstrb=4'b0101 and wdata=0xAABBCCDD -> r3 reads 0x11BB33DD. With BYPASS=1, the same-cycle read of r3 already shows 0x11BB33DD.
- Zero register: write 0xFFFFFFFF to r0 and alloc r0 -> r0 reads 0, rbusy=0 and busy_cnt is unchanged.
- Scoreboard path: alloc r7 then r9 -> busy_cnt=2. Write r7 -> busy_cnt=1. In one cycle, alloc r9 and write r9 with wstrb=0 -> r9 stays busy and busy_cnt=1.
- Flush priority: with 3 entries busy, flush+alloc r4+write r4=0x5 -> busy_cnt=0, r4 is not busy and r4 reads 0x5.
- Port stress: NUM_RD=4, all ports address r12 during a bypassed write of 0x12345678 -> all four return 0x12345678 with rbusy=0.
